// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_pkg;

    parameter int unsigned REG_ADDR_W = 5;
    parameter logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StErr     = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } stage_en_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds a source of the instruction in ID.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic                  ex_memtoreg_i,
    input  logic [REG_ADDR_W-1:0] ex_ard_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    output logic                  load_use_o
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use_o = ex_memtoreg_i && (ex_ard_i != ZERO_REG) &&
                        ((ex_ard_i == id_rs1_i) || (ex_ard_i == id_rs2_i));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage core: stage enables/flushes, memory wait
// handshake with timeout, and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ID_RS1,
    input  logic [REG_ADDR_W-1:0] ID_RS2,
    input  logic                  EX_MEMTOREG,
    input  logic [REG_ADDR_W-1:0] EX_ARD,
    input  logic                  EX_BRANCH_TAKEN,
    input  logic                  MEM_MEMWRITE,
    input  logic                  MEM_MEMTOREG,
    input  logic                  DMEM_READY,
    output logic                  DMEM_REQ,
    output logic                  EN_PC,
    output logic                  EN_IF_ID,
    output logic                  EN_ID_EX,
    output logic                  EN_EX_MEM,
    output logic                  EN_MEM_WB,
    output logic                  FLUSH_IF_ID,
    output logic                  FLUSH_ID_EX,
    output logic [CNT_W-1:0]      STALL_CNT,
    output logic                  ERR
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] MaxWaitW = WaitW'(MAX_WAIT);

    hz_state_e        state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] stall_q;

    logic      mem_acc;
    logic      load_use;
    logic      mem_stall;
    stage_en_t en;
    logic      flush_if_id;
    logic      flush_id_ex;
    logic      req;

    assign mem_acc = MEM_MEMWRITE | MEM_MEMTOREG;

    hazard_detect u_hazard_detect (
        .ex_memtoreg_i (EX_MEMTOREG),
        .ex_ard_i      (EX_ARD),
        .id_rs1_i      (ID_RS1),
        .id_rs2_i      (ID_RS2),
        .load_use_o    (load_use)
    );

    // In MEM_WAIT the access is still outstanding, so only READY releases the freeze.
    assign mem_stall = !DMEM_READY &&
                       (((state_q == StRun) && mem_acc) || (state_q == StMemWait));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            StRun: begin
                if (mem_stall) begin
                    wait_d  = WaitW'(1);
                    state_d = (MAX_WAIT <= 1) ? StErr : StMemWait;
                end
            end
            StMemWait: begin
                if (DMEM_READY) begin
                    state_d = StRun;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                    if (wait_d == MaxWaitW) begin
                        state_d = StErr;
                    end
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StRun;
                wait_d  = '0;
            end
        endcase
    end

    always_comb begin
        en          = '{pc: 1'b1, if_id: 1'b1, id_ex: 1'b1, ex_mem: 1'b1, mem_wb: 1'b1};
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        req         = mem_acc;
        if (state_q == StErr) begin
            en  = '0;
            req = 1'b0;
        end else if (mem_stall) begin
            en = '0;
        end else if (EX_BRANCH_TAKEN) begin
            // The ID instruction is squashed, so a coincident load-use is moot.
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (load_use) begin
            en.pc       = 1'b0;
            en.if_id    = 1'b0;
            flush_id_ex = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if ((state_q != StErr) && !en.pc && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign EN_PC       = rst & en.pc;
    assign EN_IF_ID    = rst & en.if_id;
    assign EN_ID_EX    = rst & en.id_ex;
    assign EN_EX_MEM   = rst & en.ex_mem;
    assign EN_MEM_WB   = rst & en.mem_wb;
    assign FLUSH_IF_ID = rst & flush_if_id;
    assign FLUSH_ID_EX = rst & flush_id_ex;
    assign DMEM_REQ    = rst & req;
    assign STALL_CNT   = stall_q;
    assign ERR         = (state_q == StErr);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int MaxWait = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_RS1, ID_RS2, EX_ARD;
    logic       EX_MEMTOREG, EX_BRANCH_TAKEN, MEM_MEMWRITE, MEM_MEMTOREG, DMEM_READY;

    logic        req_a, pc_a, ifid_a, idex_a, exmem_a, memwb_a, fif_a, fid_a, err_a;
    logic [15:0] cnt_a;
    logic        req_b, pc_b, ifid_b, idex_b, exmem_b, memwb_b, fif_b, fid_b, err_b;
    logic [3:0]  cnt_b;

    pipe_hazard_ctrl #(.MAX_WAIT(MaxWait), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .EX_MEMTOREG(EX_MEMTOREG),
        .EX_ARD(EX_ARD), .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN), .MEM_MEMWRITE(MEM_MEMWRITE),
        .MEM_MEMTOREG(MEM_MEMTOREG), .DMEM_READY(DMEM_READY), .DMEM_REQ(req_a),
        .EN_PC(pc_a), .EN_IF_ID(ifid_a), .EN_ID_EX(idex_a), .EN_EX_MEM(exmem_a),
        .EN_MEM_WB(memwb_a), .FLUSH_IF_ID(fif_a), .FLUSH_ID_EX(fid_a), .STALL_CNT(cnt_a),
        .ERR(err_a)
    );

    pipe_hazard_ctrl #(.MAX_WAIT(MaxWait), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .EX_MEMTOREG(EX_MEMTOREG),
        .EX_ARD(EX_ARD), .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN), .MEM_MEMWRITE(MEM_MEMWRITE),
        .MEM_MEMTOREG(MEM_MEMTOREG), .DMEM_READY(DMEM_READY), .DMEM_REQ(req_b),
        .EN_PC(pc_b), .EN_IF_ID(ifid_b), .EN_ID_EX(idex_b), .EN_EX_MEM(exmem_b),
        .EN_MEM_WB(memwb_b), .FLUSH_IF_ID(fif_b), .FLUSH_ID_EX(fid_b), .STALL_CNT(cnt_b),
        .ERR(err_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 = running, 1 = waiting on memory, 2 = timed out.
    int         m_st, m_wait, m_stall;
    logic [4:0] x_en;
    logic [1:0] x_fl;
    logic       x_req;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic set_idle();
        ID_RS1 = 0; ID_RS2 = 0; EX_ARD = 0; EX_MEMTOREG = 0; EX_BRANCH_TAKEN = 0;
        MEM_MEMWRITE = 0; MEM_MEMTOREG = 0; DMEM_READY = 1;
    endtask

    task automatic set_random(input int ready_pct);
        ID_RS1 = 5'($urandom_range(0, 3));
        ID_RS2 = 5'($urandom_range(0, 3));
        EX_ARD = 5'($urandom_range(0, 3));
        EX_MEMTOREG = ($urandom_range(0, 2) == 0);
        EX_BRANCH_TAKEN = ($urandom_range(0, 5) == 0);
        MEM_MEMWRITE = ($urandom_range(0, 3) == 0);
        MEM_MEMTOREG = ($urandom_range(0, 3) == 0);
        DMEM_READY = ($urandom_range(0, 99) < ready_pct);
    endtask

    task automatic model_outputs();
        logic acc, lu;
        acc = MEM_MEMWRITE | MEM_MEMTOREG;
        lu = EX_MEMTOREG && (EX_ARD != 0) && (EX_ARD == ID_RS1 || EX_ARD == ID_RS2);
        x_en  = 5'b11111;
        x_fl  = 2'b00;
        x_req = acc;
        if (m_st == 2) begin
            x_en  = 5'b00000;
            x_req = 1'b0;
        end else if (!DMEM_READY && (m_st == 1 || acc)) begin
            x_en = 5'b00000;
        end else if (EX_BRANCH_TAKEN) begin
            x_fl = 2'b11;
        end else if (lu) begin
            x_en = 5'b00111;
            x_fl = 2'b01;
        end
    endtask

    task automatic model_advance();
        logic acc;
        acc = MEM_MEMWRITE | MEM_MEMTOREG;
        if (m_st != 2 && !x_en[4]) m_stall++;
        if (m_st == 0) begin
            if (acc && !DMEM_READY) begin
                m_wait = 1;
                m_st = (m_wait >= MaxWait) ? 2 : 1;
            end
        end else if (m_st == 1) begin
            if (DMEM_READY) begin
                m_st = 0;
                m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == MaxWait) m_st = 2;
            end
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_cnt"}, 32'(cnt_a), 32'(sat(m_stall, 16)));
        check({tag, "_cnt4"}, 32'(cnt_b), 32'(sat(m_stall, 4)));
        check({tag, "_err"}, {31'd0, err_a}, {31'd0, m_st == 2});
        check({tag, "_err4"}, {31'd0, err_b}, {31'd0, m_st == 2});
    endtask

    // Inputs must already be applied; checks outputs mid-cycle, then state after the edge.
    task automatic step(input string tag);
        #1;
        model_outputs();
        check({tag, "_en"}, {27'd0, pc_a, ifid_a, idex_a, exmem_a, memwb_a}, {27'd0, x_en});
        check({tag, "_fl"}, {30'd0, fif_a, fid_a}, {30'd0, x_fl});
        check({tag, "_req"}, {31'd0, req_a}, {31'd0, x_req});
        check({tag, "_en4"}, {27'd0, pc_b, ifid_b, idex_b, exmem_b, memwb_b}, {27'd0, x_en});
        @(posedge clk);
        model_advance();
        #1;
        check_state(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {22'd0, req_a, pc_a, ifid_a, idex_a, exmem_a, memwb_a, fif_a,
              fid_a, req_b, pc_b}, 32'd0);
        check({tag, "_cnt"}, {12'd0, cnt_b, cnt_a}, 32'd0);
        check({tag, "_err"}, {30'd0, err_a, err_b}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_random(50);
        #1;
        check_all_zero("rst_a");
        repeat (2) begin
            @(posedge clk);
            #1;
            set_random(50);
            #1;
            check_all_zero("rst_b");
        end
        m_st = 0; m_wait = 0; m_stall = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        set_idle();
        m_st = 0; m_wait = 0; m_stall = 0;
        do_reset();

        set_idle();
        step("idle");
        check("idle_en_all", {27'd0, pc_a, ifid_a, idex_a, exmem_a, memwb_a}, 32'h1f);

        set_idle(); EX_MEMTOREG = 1; EX_ARD = 5; ID_RS2 = 5; ID_RS1 = 3;
        step("lu");
        set_idle();
        step("lu_after");
        check("lu_total", 32'(cnt_a), 32'd1);

        set_idle(); EX_MEMTOREG = 1; EX_ARD = 0; ID_RS1 = 0; ID_RS2 = 0;
        step("lu_x0");

        set_idle(); EX_MEMTOREG = 1; EX_ARD = 7; ID_RS1 = 7; EX_BRANCH_TAKEN = 1;
        step("br_lu");

        set_idle(); MEM_MEMTOREG = 1; DMEM_READY = 0;
        repeat (3) step("mwait");
        DMEM_READY = 1;
        step("mrel");
        check("mwait_total", 32'(cnt_a), 32'd4);

        set_idle(); MEM_MEMWRITE = 1; DMEM_READY = 0;
        repeat (MaxWait) step("tmo");
        check("tmo_err", {31'd0, err_a}, 32'd1);
        repeat (4) begin
            set_random(50);
            step("in_err");
        end
        do_reset();

        set_idle(); EX_MEMTOREG = 1; EX_ARD = 2; ID_RS1 = 2;
        repeat (20) step("sat");
        check("sat_cnt4", 32'(cnt_b), 32'hf);

        for (int blk = 0; blk < 40; blk++) begin
            int pct = (blk % 4 == 3) ? 5 : 70;
            for (int i = 0; i < 50; i++) begin
                if ((m_st == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
                    do_reset();
                end
                set_random(pct);
                // The frozen EX register keeps its branch indication stable while waiting.
                if (m_st == 1) EX_BRANCH_TAKEN = 1'b0;
                step("rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
